// File: rtl/chdr_pkt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// chdr_pkt_rr_arbiter
//
// Packet-atomic round-robin arbiter. Merges PORTS 64-bit CHDR streams onto a
// single stream. Once a port is granted, its whole packet is forwarded before
// any other port is considered. Each port has an enable bit and an optional
// header rewrite (SID in [31:0], per-port 12-bit seqnum in [59:48]), both
// programmed over the settings bus.
//
// Settings map: BASE+2p -> ctrl[p] (bit0 enable, bit1 rewrite)
//               BASE+2p+1 -> sid[p]
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   set_stb/addr/data     settings bus write
//   i_tdata/tlast/tvalid  input streams, port p in i_tdata[64p+63:64p]
//   i_tready              per-port ready, only the granted port can be ready
//   o_tdata/tlast/tvalid  merged output stream (pure mux, zero latency)
//   o_tready              downstream ready
//   grant                 index of granted port, meaningful while busy=1
//   busy                  a packet is in flight
// -----------------------------------------------------------------------------
module chdr_pkt_rr_arbiter #(
   parameter int unsigned PORTS = 4,
   parameter int unsigned BASE  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                set_stb,
   input  logic [7:0]          set_addr,
   input  logic [31:0]         set_data,
   input  logic [64*PORTS-1:0] i_tdata,
   input  logic [PORTS-1:0]    i_tlast,
   input  logic [PORTS-1:0]    i_tvalid,
   output logic [PORTS-1:0]    i_tready,
   output logic [63:0]         o_tdata,
   output logic                o_tlast,
   output logic                o_tvalid,
   input  logic                o_tready,
   output logic [2:0]          grant,
   output logic                busy
);

   typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

   state_e      r_state;
   state_e      w_state_nxt;
   logic [2:0]  r_grant;
   logic [2:0]  r_last;
   logic        r_busy;
   logic [1:0]  r_ctrl [PORTS];
   logic [31:0] r_sid  [PORTS];
   logic [11:0] r_seq  [PORTS];

   logic [PORTS-1:0] w_req;
   logic [PORTS-1:0] w_gnt_oh;
   logic [2:0]       w_pick;
   logic             w_found;
   int unsigned      w_dist;
   int unsigned      w_best;
   logic [63:0]      w_sel_data;
   logic             w_sel_last;
   logic             w_sel_valid;
   logic             w_sel_rw;
   logic [31:0]      w_sel_sid;
   logic [11:0]      w_sel_seq;
   logic             w_hs;

   // Requests are masked by the enable bit; disabled ports are simply never picked.
   always_comb begin
      w_req = '0;
      for (int p = 0; p < PORTS; p++) begin
         w_req[p] = i_tvalid[p] & r_ctrl[p][0];
      end
   end

   // Round robin: the requester with the smallest circular distance from last+1 wins.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_dist  = 0;
      w_best  = PORTS;
      for (int p = 0; p < PORTS; p++) begin
         w_dist = (32'(p) + 2 * PORTS - 1 - 32'(r_last)) % PORTS;
         if (w_req[p] && (w_dist < w_best)) begin
            w_best  = w_dist;
            w_pick  = 3'(p);
            w_found = 1'b1;
         end
      end
   end

   // Select the granted port's stream and its settings.
   always_comb begin
      w_gnt_oh    = '0;
      w_sel_data  = '0;
      w_sel_last  = 1'b0;
      w_sel_valid = 1'b0;
      w_sel_rw    = 1'b0;
      w_sel_sid   = '0;
      w_sel_seq   = '0;
      for (int p = 0; p < PORTS; p++) begin
         if (r_grant == 3'(p)) begin
            w_gnt_oh[p] = 1'b1;
            w_sel_data  = i_tdata[64*p +: 64];
            w_sel_last  = i_tlast[p];
            w_sel_valid = i_tvalid[p];
            w_sel_rw    = r_ctrl[p][1];
            w_sel_sid   = r_sid[p];
            w_sel_seq   = r_seq[p];
         end
      end
   end

   // FSM next state and output mux.
   always_comb begin
      w_state_nxt = r_state;
      o_tdata     = '0;
      o_tlast     = 1'b0;
      o_tvalid    = 1'b0;
      i_tready    = '0;
      w_hs        = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_found) w_state_nxt = StHdr;
         end
         StHdr: begin
            o_tvalid = w_sel_valid;
            o_tlast  = w_sel_last;
            o_tdata  = w_sel_rw ? {w_sel_data[63:60], w_sel_seq, w_sel_data[47:32], w_sel_sid}
                                : w_sel_data;
            i_tready = w_gnt_oh & {PORTS{o_tready}};
            w_hs     = w_sel_valid & o_tready;
            if (w_hs) w_state_nxt = w_sel_last ? StIdle : StBody;
         end
         StBody: begin
            o_tvalid = w_sel_valid;
            o_tlast  = w_sel_last;
            o_tdata  = w_sel_data;
            i_tready = w_gnt_oh & {PORTS{o_tready}};
            w_hs     = w_sel_valid & o_tready;
            if (w_hs && w_sel_last) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
         r_grant <= '0;
         r_busy  <= 1'b0;
         r_last  <= 3'(PORTS - 1);
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == StIdle) && w_found) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
         end
         // End of packet, including a 1-beat packet finishing in the header state.
         if ((r_state != StIdle) && w_hs && w_sel_last) begin
            r_last <= r_grant;
            r_busy <= 1'b0;
         end
      end
   end

   // Settings registers and per-port sequence numbers. A header beat coinciding
   // with a settings write sees the old values because both are registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < PORTS; p++) begin
            r_ctrl[p] <= 2'b01;
            r_sid[p]  <= '0;
            r_seq[p]  <= '0;
         end
      end else begin
         for (int p = 0; p < PORTS; p++) begin
            if (set_stb && (set_addr == 8'(BASE + 2 * p))) r_ctrl[p] <= set_data[1:0];
            if (set_stb && (set_addr == 8'(BASE + 2 * p + 1))) r_sid[p] <= set_data;
            if ((r_state == StHdr) && w_hs && w_sel_rw && (r_grant == 3'(p))) begin
               r_seq[p] <= r_seq[p] + 12'd1;
            end
         end
      end
   end

   assign grant = r_grant;
   assign busy  = r_busy;

endmodule

// File: tb/tb_chdr_pkt_rr_arbiter.sv
module tb_chdr_pkt_rr_arbiter;

   localparam int unsigned PORTS = 4;
   localparam int unsigned BASE  = 8;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                set_stb = 1'b0;
   logic [7:0]          set_addr = '0;
   logic [31:0]         set_data = '0;
   logic [64*PORTS-1:0] i_tdata;
   logic [PORTS-1:0]    i_tlast;
   logic [PORTS-1:0]    i_tvalid;
   logic [PORTS-1:0]    i_tready;
   logic [63:0]         o_tdata;
   logic                o_tlast;
   logic                o_tvalid;
   logic                o_tready;
   logic [2:0]          grant;
   logic                busy;

   always #5 clk = ~clk;

   chdr_pkt_rr_arbiter #(.PORTS(PORTS), .BASE(BASE)) dut (
      .clk      (clk),
      .reset    (reset),
      .set_stb  (set_stb),
      .set_addr (set_addr),
      .set_data (set_data),
      .i_tdata  (i_tdata),
      .i_tlast  (i_tlast),
      .i_tvalid (i_tvalid),
      .i_tready (i_tready),
      .o_tdata  (o_tdata),
      .o_tlast  (o_tlast),
      .o_tvalid (o_tvalid),
      .o_tready (o_tready),
      .grant    (grant),
      .busy     (busy)
   );

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } beat_t;

   beat_t src_q [PORTS][$];   // beats still to be presented by each source
   beat_t ref_q [PORTS][$];   // beats still expected on the output, per source

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pkt_id = 0;
   bit tready_toggle = 1'b0;

   // Output log, filled by the compare process.
   int          log_port [$];
   int          log_first [$];
   int          log_lastc [$];
   logic [63:0] log_hdr [$];
   int          beat_count = 0;
   int          last_count = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] def_hdr(input int p);
      def_hdr = {8'(p), 8'(pkt_id), 16'hC0DE, 32'hFFFF_0000 | 32'(pkt_id)};
   endfunction

   task automatic push_pkt(input int p, input int n, input logic [63:0] hdr);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.data = (k == 0) ? hdr : {8'(p), 8'(pkt_id), 16'h5A5A, 32'(k)};
         b.last = (k == n - 1);
         src_q[p].push_back(b);
         ref_q[p].push_back(b);
      end
      pkt_id++;
   endtask

   task automatic clear_log();
      log_port.delete();
      log_first.delete();
      log_lastc.delete();
      log_hdr.delete();
      beat_count = 0;
      last_count = 0;
   endtask

   task automatic set_write(input logic [7:0] a, input logic [31:0] d);
      @(posedge clk); #2;
      set_stb = 1'b1; set_addr = a; set_data = d;
      @(posedge clk); #2;
      set_stb = 1'b0;
   endtask

   task automatic drain(input int limit);
      bit done;
      done = 1'b0;
      for (int k = 0; k < limit && !done; k++) begin
         @(posedge clk); #2;
         done = !busy;
         for (int p = 0; p < PORTS; p++) begin
            if (src_q[p].size() != 0 || ref_q[p].size() != 0) done = 1'b0;
         end
      end
      chk("drain_timeout", 64'(done), 64'd1);
   endtask

   // Source driver: one process presents the head of every port's queue and
   // retires it after an observed input handshake.
   logic [PORTS-1:0] hs_seen;
   initial begin
      i_tvalid = '0;
      i_tlast  = '0;
      i_tdata  = '0;
      o_tready = 1'b1;
      forever begin
         @(negedge clk);
         hs_seen = i_tvalid & i_tready;
         @(posedge clk); #1;
         for (int p = 0; p < PORTS; p++) begin
            if (hs_seen[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            if (src_q[p].size() > 0) begin
               i_tvalid[p] = 1'b1;
               i_tdata[64*p +: 64] = src_q[p][0].data;
               i_tlast[p] = src_q[p][0].last;
            end else begin
               i_tvalid[p] = 1'b0;
               i_tlast[p]  = 1'b0;
            end
         end
         o_tready = tready_toggle ? ~o_tready : 1'b1;
      end
   end

   // Behavioural model: busy flag, granted port, first-beat flag, round-robin
   // pointer, shadow settings and seqnums. Checked every cycle at negedge.
   bit               m_busy;
   bit               m_hdr;
   int               m_grant;
   int               m_last;
   int               mq;
   int               moff;
   bit               m_pick;
   logic [1:0]       m_ctrl [PORTS];
   logic [31:0]      m_sid  [PORTS];
   logic [11:0]      m_seq  [PORTS];
   logic [63:0]      m_src;
   logic [63:0]      m_exp;
   logic [PORTS-1:0] m_rdy;
   beat_t            m_rb;
   bit               m_hs;

   task automatic model_reset();
      m_busy  = 1'b0;
      m_hdr   = 1'b0;
      m_grant = 0;
      m_last  = int'(PORTS) - 1;
      for (int p = 0; p < PORTS; p++) begin
         m_ctrl[p] = 2'b01;
         m_sid[p]  = '0;
         m_seq[p]  = '0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            model_reset();
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_tvalid", 64'(o_tvalid), 64'd0);
            chk("rst_tready", 64'(i_tready), 64'd0);
            continue;
         end
         chk("busy", 64'(busy), 64'(m_busy));
         m_rdy = '0;
         m_hs  = 1'b0;
         if (m_busy) begin
            chk("grant", 64'(grant), 64'(m_grant));
            if (o_tready) m_rdy[m_grant] = 1'b1;
            chk("i_tready", 64'(i_tready), 64'(m_rdy));
            chk("o_tvalid", 64'(o_tvalid), 64'(i_tvalid[m_grant]));
            m_src = i_tdata[64*m_grant +: 64];
            m_exp = m_src;
            if (m_hdr && m_ctrl[m_grant][1]) begin
               m_exp[31:0]  = m_sid[m_grant];
               m_exp[59:48] = m_seq[m_grant];
            end
            if (i_tvalid[m_grant]) begin
               chk("o_tdata", o_tdata, m_exp);
               chk("o_tlast", 64'(o_tlast), 64'(i_tlast[m_grant]));
            end
            m_hs = i_tvalid[m_grant] && o_tready;
         end else begin
            chk("idle_tvalid", 64'(o_tvalid), 64'd0);
            chk("idle_tready", 64'(i_tready), 64'd0);
         end

         if (m_hs) begin
            // Scoreboard: the output beat must be the next beat this source queued.
            if (ref_q[m_grant].size() == 0) begin
               chk("sb_extra_beat", 64'd1, 64'd0);
            end else begin
               m_rb = ref_q[m_grant].pop_front();
               if (m_hdr && m_ctrl[m_grant][1]) begin
                  m_rb.data[31:0]  = m_sid[m_grant];
                  m_rb.data[59:48] = m_seq[m_grant];
               end
               chk("sb_data", o_tdata, m_rb.data);
               chk("sb_last", 64'(o_tlast), 64'(m_rb.last));
            end
            beat_count++;
            if (o_tlast) last_count++;
            if (m_hdr) begin
               log_port.push_back(int'(grant));
               log_first.push_back(cyc);
               log_hdr.push_back(o_tdata);
               if (m_ctrl[m_grant][1]) m_seq[m_grant] = m_seq[m_grant] + 12'd1;
            end
            m_hdr = 1'b0;
            if (i_tlast[m_grant]) begin
               log_lastc.push_back(cyc);
               m_busy = 1'b0;
               m_last = m_grant;
            end
         end else if (!m_busy) begin
            m_pick = 1'b0;
            for (int i = 1; i <= int'(PORTS); i++) begin
               mq = (m_last + i) % int'(PORTS);
               if (!m_pick && i_tvalid[mq] && m_ctrl[mq][0]) begin
                  m_pick  = 1'b1;
                  m_grant = mq;
               end
            end
            if (m_pick) begin
               m_busy = 1'b1;
               m_hdr  = 1'b1;
            end
         end

         // Settings take effect after this cycle's beat used the old values.
         if (set_stb && int'(set_addr) >= int'(BASE) && int'(set_addr) < int'(BASE + 2 * PORTS)) begin
            moff = int'(set_addr) - int'(BASE);
            if (moff % 2 == 0) m_ctrl[moff / 2] = set_data[1:0];
            else               m_sid[moff / 2]  = set_data;
         end
      end
   end

   int n;
   bit seen;

   initial begin
      // Reset values.
      repeat (3) @(posedge clk);
      #2;
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_busy_lit", 64'(busy), 64'd0);
      chk("rst_tvalid_lit", 64'(o_tvalid), 64'd0);
      @(posedge clk); #3;
      reset = 1'b1;

      // Four simultaneous 8-beat packets: order 0,1,2,3, contiguous, 1-cycle gap.
      clear_log();
      @(posedge clk); #2;
      for (int p = 0; p < PORTS; p++) push_pkt(p, 8, def_hdr(p));
      drain(300);
      chk("t1_npkt", 64'(log_port.size()), 64'd4);
      if (log_port.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("t1_order", 64'(log_port[i]), 64'(i));
            chk("t1_contig", 64'(log_lastc[i] - log_first[i]), 64'd7);
            if (i > 0) chk("t1_gap", 64'(log_first[i] - log_lastc[i-1] - 1), 64'd1);
         end
      end

      // Port 1 continuous, port 2 one packet: 1,2,1,1,1.
      clear_log();
      @(posedge clk); #2;
      for (int k = 0; k < 4; k++) push_pkt(1, 4, def_hdr(1));
      push_pkt(2, 4, def_hdr(2));
      drain(300);
      chk("t2_npkt", 64'(log_port.size()), 64'd5);
      if (log_port.size() == 5) begin
         chk("t2_g0", 64'(log_port[0]), 64'd1);
         chk("t2_g1", 64'(log_port[1]), 64'd2);
         chk("t2_g2", 64'(log_port[2]), 64'd1);
      end

      // Header rewrite on port 1.
      set_write(8'(BASE + 2), 32'h3);
      set_write(8'(BASE + 3), 32'h0004_0005);
      clear_log();
      @(posedge clk); #2;
      for (int k = 0; k < 3; k++) push_pkt(1, 3, {4'h1, 12'h7AB, 16'hBEEF, 32'h0002_0003});
      drain(200);
      chk("t3_npkt", 64'(log_hdr.size()), 64'd3);
      if (log_hdr.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            chk("t3_hdr", log_hdr[k], {4'h1, 12'(k), 16'hBEEF, 32'h0004_0005});
         end
      end
      set_write(8'(BASE + 2), 32'h1);

      // Disable port 2 while it is valid, then re-enable.
      set_write(8'(BASE + 4), 32'h0);
      clear_log();
      @(posedge clk); #2;
      push_pkt(2, 2, def_hdr(2));
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #2;
         chk("t4_blocked_rdy", 64'(i_tready[2]), 64'd0);
         chk("t4_blocked_busy", 64'(busy), 64'd0);
      end
      @(posedge clk); #2;
      set_stb = 1'b1; set_addr = 8'(BASE + 4); set_data = 32'h1;
      n = 0;
      seen = 1'b0;
      for (int k = 1; k <= 10 && !seen; k++) begin
         @(posedge clk); #2;
         set_stb = 1'b0;
         if (busy && grant == 3'd2) begin
            seen = 1'b1;
            n = k;
         end
      end
      chk("t4_regrant", 64'(seen), 64'd1);
      chk("t4_latency", 64'(n), 64'd2);
      drain(100);

      // o_tready toggling: 9-beat on port 0 and 1-beat on port 3 (pointer at 2 -> 3 first).
      clear_log();
      tready_toggle = 1'b1;
      @(posedge clk); #2;
      push_pkt(0, 9, def_hdr(0));
      push_pkt(3, 1, def_hdr(3));
      drain(300);
      tready_toggle = 1'b0;
      chk("t5_beats", 64'(beat_count), 64'd10);
      chk("t5_lasts", 64'(last_count), 64'd2);
      chk("t5_npkt", 64'(log_port.size()), 64'd2);
      if (log_port.size() == 2) begin
         chk("t5_first", 64'(log_port[0]), 64'd3);
         chk("t5_second", 64'(log_port[1]), 64'd0);
      end

      // Reset in the middle of a port 0 packet.
      clear_log();
      @(posedge clk); #2;
      push_pkt(0, 8, def_hdr(0));
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(posedge clk); #2;
         seen = (beat_count >= 3);
      end
      chk("t6_midpkt", 64'(seen), 64'd1);
      push_pkt(2, 4, def_hdr(2));
      #1;
      reset = 1'b0;
      for (int p = 0; p < PORTS; p++) begin
         src_q[p].delete();
         ref_q[p].delete();
      end
      #1;
      chk("t6_tvalid_now", 64'(o_tvalid), 64'd0);
      chk("t6_busy_now", 64'(busy), 64'd0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      clear_log();
      @(posedge clk); #2;
      push_pkt(1, 3, def_hdr(1));
      push_pkt(2, 3, def_hdr(2));
      push_pkt(0, 3, def_hdr(0));
      drain(200);
      chk("t6_npkt", 64'(log_port.size()), 64'd3);
      if (log_port.size() == 3) begin
         for (int i = 0; i < 3; i++) chk("t6_order", 64'(log_port[i]), 64'(i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
